// File: rtl/uart_pkg.sv
// Shared types and constants for the tester's UART transmitter.
package uart_pkg;

  // Transmitter sequence: launch, start bit, eight data bits, optional parity,
  // stop bit, one-cycle done pulse, then wait for the enable to be released.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    HOLD
  } tx_state_e;

  localparam int UART_DATA_W = 8;

  // Header placed in byte bits [7:6]; matches the host "send state" command code.
  localparam logic [1:0] STATUS_HDR_DEFAULT = 2'b01;

  // Clock cycles per serial bit. The result must be at least 2 for the
  // baud counter to have a meaningful width.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter. Produces a one-cycle tick on the
// last cycle of each bit period; a synchronous clear restarts the period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // Count cycles within a bit, wrapping after the last one or on a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter reporting the 6-bit switch state behind a 2-bit status
// header. Outputs are registered from the current state, so every line change
// trails the state change by one cycle.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115_200,
  parameter logic [1:0] STATUS_HDR = STATUS_HDR_DEFAULT
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_s_en,
  input  logic [5:0] in_data,
  output logic       out_tx,
  output logic       out_s_bs,
  output logic       out_s_rd
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_W - 1);

  tx_state_e r_state;
  tx_state_e w_next;

  logic [UART_DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]       r_idx;

  logic w_tick;
  logic w_clear;
  logic w_tx;
  logic w_bs;
  logic w_rd;
  logic r_tx;
  logic r_bs;
  logic r_rd;

`ifdef UART_TX_PARITY_EN
  logic r_parity;
`endif

  // The bit timer restarts whenever the state changes so every bit is full length.
  assign w_clear = (w_next != r_state);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .i_clk  (in_clk),
    .i_rst_n(in_rst),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state line/flag values; HOLD blocks relaunch from a held enable.
  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    w_bs   = 1'b1;
    w_rd   = 1'b0;
    case (r_state)
      IDLE: begin
        w_bs = 1'b0;
        if (in_s_en) w_next = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_tick && (r_idx == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx = r_parity;
        if (w_tick) w_next = STOP;
      end
`endif
      STOP: begin
        if (w_tick) w_next = DONE;
      end
      DONE: begin
        w_rd   = 1'b1;
        w_next = HOLD;
      end
      HOLD: begin
        if (!in_s_en) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
        w_tx   = 1'b1;
        w_bs   = 1'b0;
      end
    endcase
  end

  // Register the state-decoded outputs so the pins are glitch-free.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_tx <= 1'b1;
      r_bs <= 1'b0;
      r_rd <= 1'b0;
    end else begin
      r_tx <= w_tx;
      r_bs <= w_bs;
      r_rd <= w_rd;
    end
  end

  // Capture the byte at launch, then shift it out LSB first one bit per period.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if ((r_state == IDLE) && in_s_en) begin
      r_shift <= {STATUS_HDR, in_data};
      r_idx   <= '0;
    end else if ((r_state == DATA) && w_tick) begin
      r_shift <= r_shift >> 1;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity is taken from the launched byte, since the shifter consumes it.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_parity <= 1'b0;
    end else if ((r_state == IDLE) && in_s_en) begin
      r_parity <= ^{STATUS_HDR, in_data};
    end
  end
`endif

  assign out_tx   = r_tx;
  assign out_s_bs = r_bs;
  assign out_s_rd = r_rd;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter downstream of the tester control FSM.
- When the FSM raises its send-enable, the block sends the current 6-bit switch state as one 8N1 UART byte on the TX pin.
- The byte is a 2-bit status header followed by the 6 data bits.
- Returns busy and done flags that drive the FSM's WAIT -> SEND -> IDLE transitions.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), must be >= 2.
- STATUS_HDR, 2'b01, value placed in byte bits [7:6]; matches the host "send state" command code.

Ports:
- in_clk  input  1  system clock.
- in_rst  input  1  asynchronous reset, active low.
- in_s_en  input  1  send enable from control FSM; level, held high through FSM WAIT/SEND.
- in_data  input  6  switch/memory state to report.
- out_tx  output  1  UART TX line; idle high.
- out_s_bs  output  1  busy flag.
- out_s_rd  output  1  done flag; one-cycle pulse.

Behaviour:
- Reset (asynchronous, active low, takes effect immediately):
  - out_tx=1, out_s_bs=0, out_s_rd=0.
  - State IDLE; baud counter, bit index and shift register all 0.
- Frame format: start(0), byte[0]..byte[7] LSB first, stop(1).
  - byte = {STATUS_HDR, in_data}, captured at the launch edge.
- Bit timing: every bit, start and stop included, is held exactly CLKS_PER_BIT cycles, timed by a counter that restarts at 0 on every state change.
- States:
  - IDLE: out_tx=1, bs=0. If in_s_en=1 at the edge: latch byte, go START. Launch latency 1 cycle.
  - START: out_tx=0. After CLKS_PER_BIT cycles go DATA with index=0.
  - DATA: out_tx=shift[0]. Every CLKS_PER_BIT cycles shift right and increment index. After index 7 completes go STOP (or PARITY, see Optional Feature).
  - STOP: out_tx=1. After CLKS_PER_BIT cycles go DONE.
  - DONE: one cycle, out_s_rd=1, out_tx=1, go HOLD.
  - HOLD: out_tx=1. Stay until in_s_en=0, then go IDLE. This blocks a second transmit from the level-held enable.
- out_s_bs=1 in every state except IDLE (registered, state-decoded). With a held enable it rises the cycle after in_s_en is first sampled.
- in_data changes after launch have no effect on the frame in flight.
- in_s_en dropping mid-frame does not abort the frame; the frame completes and s_rd still pulses.
  - If in_s_en is already 0 on entry to HOLD, HOLD lasts 1 cycle.
- Reset mid-frame: line returns high immediately and no s_rd pulse is issued.
- Timing from launch edge: s_rd asserts 10*CLKS_PER_BIT+1 cycles later (11*CLKS_PER_BIT+1 with parity).
- No unreachable-state lockup: the default branch goes to IDLE with out_tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP drives the even-parity bit (XOR of the 8 byte bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- Undefined: no PARITY state exists; DATA goes directly to STOP; frame is 10 bits.

Decomposition:
- Package uart_pkg:
  - tx_state_e enum: IDLE, START, DATA, PARITY, STOP, DONE, HOLD.
  - UART_DATA_W=8 and the STATUS_HDR default constant.
  - A CLKS_PER_BIT helper function.
- Sub-module uart_baud_gen (natural split):
  - Counter of width $clog2(CLKS_PER_BIT) with synchronous clear input.
  - One-cycle tick output at count CLKS_PER_BIT-1.
  - The uart_tx FSM advances only on tick.

Test Plan (CLK_FREQ=8, BAUD=1, so CLKS_PER_BIT=8):
- Basic send:
  - Stimulus: in_data=6'b101101, in_s_en held high.
  - Response: out_tx reads 0, then 1,0,1,1,0,1,1,0 (0x6D LSB first), then 1, each bit 8 cycles.
  - s_rd pulses once 81 cycles after launch; bs high from launch+1 until return to IDLE.
- Held enable:
  - Stimulus: keep in_s_en=1 for 200 cycles after s_rd.
  - Response: no second start bit, bs stays 1 in HOLD. Drop in_s_en: bs=0 two cycles later.
- Data change:
  - Stimulus: change in_data to 6'b000000 at cycle 20 of the frame.
  - Response: transmitted byte remains 0x6D.
- Reset mid-frame:
  - Stimulus: assert in_rst low during DATA bit 3.
  - Response: out_tx=1, bs=0 asynchronously; no s_rd. After release, a new in_s_en sends a full clean frame.
- Back-to-back:
  - Stimulus: drop in_s_en after s_rd, raise it again after 2 cycles with in_data=6'b000001.
  - Response: second frame carries byte 0x41.
- UART_TX_PARITY_EN:
  - Stimulus: in_data=6'b101101.
  - Response: parity bit=1 appears before stop; s_rd pulses at 89 cycles.
